// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS-subset datapath: sequences fetch/decode/execute/
// memory/writeback, drives every datapath strobe, detects bad opcodes and memory stalls.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic [5:0]             opcode,
    input  logic                   memReady,
    output logic                   pcWrite,
    output logic                   pcWriteCond,
    output logic                   iorD,
    output logic                   memRead,
    output logic                   memWrite,
    output logic                   irWrite,
    output logic                   memToReg,
    output logic                   regDst,
    output logic                   regWriteEnable,
    output logic                   aluSrcA,
    output logic [1:0]             aluSrcB,
    output logic [1:0]             aluOp,
    output logic [1:0]             pcSource,
    output logic [3:0]             state,
    output logic [COUNT_WIDTH-1:0] instrCount,
    output logic                   error
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXEC     = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11,
        ERROR    = 4'd12
    } stateT;

    stateT                  stateReg, stateNext;
    logic [TW-1:0]          stallReg, stallNext;
    logic [COUNT_WIDTH-1:0] countReg, countNext;
    logic                   stalled, timedOut, retire;

    // Stall counter runs only while a memory-facing state waits on memReady.
    always_comb begin
        stalled   = ((stateReg == FETCH) || (stateReg == MEMRD) || (stateReg == MEMWR)) && !memReady;
        stallNext = stalled ? stallReg + 1'b1 : '0;
        timedOut  = (MEM_TIMEOUT > 0) && stalled && (stallNext == TW'(MEM_TIMEOUT));
    end

    always_comb begin
        stateNext = stateReg;
        unique case (stateReg)
            FETCH:    if (memReady) stateNext = DECODE;
            DECODE: begin
                unique case (opcode)
                    OP_RTYPE:      stateNext = EXEC;
                    OP_LW, OP_SW:  stateNext = MEMADR;
                    OP_BEQ:        stateNext = BRANCH;
                    OP_ADDI:       stateNext = ADDIEXEC;
                    OP_J:          stateNext = JUMP;
                    default:       stateNext = ERROR;
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LW)      stateNext = MEMRD;
                else if (opcode == OP_SW) stateNext = MEMWR;
                else                      stateNext = ERROR;
            end
            MEMRD:    if (memReady) stateNext = MEMWB;
            MEMWR:    if (memReady) stateNext = FETCH;
            EXEC:     stateNext = ALUWB;
            ADDIEXEC: stateNext = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: stateNext = FETCH;
            ERROR:    stateNext = ERROR;
            default:  stateNext = ERROR;
        endcase
        if (timedOut) stateNext = ERROR;
    end

    always_comb begin
        retire = (stateReg == MEMWB) || (stateReg == ALUWB) || (stateReg == ADDIWB) ||
                 (stateReg == BRANCH) || (stateReg == JUMP) ||
                 ((stateReg == MEMWR) && memReady);
        countNext = retire ? countReg + 1'b1 : countReg;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stateReg <= FETCH;
            stallReg <= '0;
            countReg <= '0;
        end else begin
            stateReg <= stateNext;
            stallReg <= stallNext;
            countReg <= countNext;
        end
    end

    // Moore strobes per state; the FETCH load strobes follow memReady but are
    // held off while reset is asserted.
    always_comb begin
        pcWrite        = 1'b0;
        pcWriteCond    = 1'b0;
        iorD           = 1'b0;
        memRead        = 1'b0;
        memWrite       = 1'b0;
        irWrite        = 1'b0;
        memToReg       = 1'b0;
        regDst         = 1'b0;
        regWriteEnable = 1'b0;
        aluSrcA        = 1'b0;
        aluSrcB        = 2'b00;
        aluOp          = 2'b00;
        pcSource       = 2'b00;
        unique case (stateReg)
            FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady && resetN;
                pcWrite = memReady && resetN;
            end
            DECODE:   aluSrcB = 2'b11;
            MEMADR, ADDIEXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            MEMRD: begin
                iorD    = 1'b1;
                memRead = 1'b1;
            end
            MEMWB: begin
                memToReg       = 1'b1;
                regWriteEnable = 1'b1;
            end
            MEMWR: begin
                iorD     = 1'b1;
                memWrite = 1'b1;
            end
            EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
            end
            ALUWB: begin
                regDst         = 1'b1;
                regWriteEnable = 1'b1;
            end
            ADDIWB:   regWriteEnable = 1'b1;
            BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcSource    = 2'b01;
                pcWriteCond = 1'b1;
            end
            JUMP: begin
                pcSource = 2'b10;
                pcWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state      = stateReg;
    assign instrCount = countReg;
    assign error      = (stateReg == ERROR);

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore/Mealy FSM that sequences the multicycle MIPS-subset datapath (fetch, decode, execute, memory, writeback).
- Decodes the 6-bit opcode from the instruction register and drives every datapath control strobe, including regWriteEnable.
- Stalls on a memory-ready handshake, flags illegal opcodes and memory timeouts, and counts retired instructions for bench debug displays.

Parameters:
- MEM_TIMEOUT, 16: consecutive stalled memory cycles before ERROR; 0 disables the timeout.
- COUNT_WIDTH, 32: width of instrCount.

Ports:
- clock  input  1  system clock, rising edge
- resetN  input  1  asynchronous active-low reset
- opcode  input  6  instruction[31:26] from the instruction register
- memReady  input  1  memory access completes this cycle
- pcWrite  output  1  unconditional PC load
- pcWriteCond  output  1  PC load if ALU zero (branch)
- iorD  output  1  memory address: 0 = PC, 1 = ALU out
- memRead  output  1  memory read request
- memWrite  output  1  memory write request
- irWrite  output  1  load instruction register
- memToReg  output  1  writeback source: 1 = memory data
- regDst  output  1  destination register: 1 = rd, 0 = rt
- regWriteEnable  output  1  register file write
- aluSrcA  output  1  0 = PC, 1 = regA
- aluSrcB  output  2  00 = regB, 01 = const 4, 10 = sign-extended immediate, 11 = immediate<<2
- aluOp  output  2  00 = add, 01 = subtract, 10 = funct decode
- pcSource  output  2  00 = ALU result, 01 = ALU out register, 10 = jump target
- state  output  4  current state, debug
- instrCount  output  COUNT_WIDTH  retired instructions
- error  output  1  sticky fault flag

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, ERROR=12. Codes 13-15 go to ERROR.
- Reset (resetN low, asynchronous): state=FETCH, instrCount=0, error=0, timeout counter=0. While resetN is low, pcWrite=irWrite=0. All other outputs take FETCH values.
- Per-state outputs; any signal not listed is 0:
  - FETCH: memRead=1, aluSrcB=01. irWrite=pcWrite=memReady (Mealy).
  - DECODE: aluSrcB=11.
  - MEMADR and ADDIEXEC: aluSrcA=1, aluSrcB=10.
  - MEMRD: iorD=1, memRead=1.
  - MEMWB: memToReg=1, regWriteEnable=1.
  - MEMWR: iorD=1, memWrite=1.
  - EXEC: aluSrcA=1, aluOp=10.
  - ALUWB: regDst=1, regWriteEnable=1.
  - ADDIWB: regWriteEnable=1.
  - BRANCH: aluSrcA=1, aluOp=01, pcSource=01, pcWriteCond=1.
  - JUMP: pcSource=10, pcWrite=1.
  - ERROR: all strobes 0, error=1.
- Transitions:
  - FETCH→DECODE when memReady=1; otherwise hold.
  - DECODE by opcode: 0x00→EXEC; 0x23 or 0x2B→MEMADR; 0x04→BRANCH; 0x08→ADDIEXEC; 0x02→JUMP; any other→ERROR.
  - MEMADR: opcode 0x23→MEMRD, 0x2B→MEMWR.
  - MEMRD→MEMWB when memReady=1; otherwise hold.
  - MEMWR→FETCH when memReady=1; otherwise hold.
  - EXEC→ALUWB. ADDIEXEC→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP→FETCH.
  - ERROR holds until reset.
- opcode is sampled combinationally in DECODE and MEMADR. The IR is stable after FETCH, so opcode must not change mid-instruction.
- Retirement: instrCount += 1 on each edge that leaves MEMWB, ALUWB, ADDIWB, BRANCH or JUMP, and on the edge that leaves MEMWR with memReady=1. The count wraps modulo 2^COUNT_WIDTH. It never increments in ERROR.
- Timeout:
  - The counter increments on each cycle in FETCH, MEMRD or MEMWR with memReady=0.
  - It clears on any cycle with memReady=1 or in any other state.
  - If MEM_TIMEOUT>0 and the counter would reach MEM_TIMEOUT on an edge, next state=ERROR instead of hold.
- Cycle counts with memReady=1: R-type, addi, lw-read path 4/4/5; sw 4; beq and j 3.
- Reset mid-instruction aborts with no retirement. The next cycle after release is FETCH.

Test Plan:
- Reset, opcode 0x00, memReady=1 → state 0,1,6,7,0; regWriteEnable=1 only in state 7 with regDst=1; instrCount=1 after 4 cycles.
- lw (0x23), memReady=0 for 3 cycles in MEMRD → state 3 held 4 cycles with memRead=iorD=1; then MEMWB with memToReg=1; instrCount+1; 8 cycles total.
- beq (0x04) then j (0x02) → BRANCH drives pcWriteCond=1, aluOp=01, pcSource=01; JUMP drives pcWrite=1, pcSource=10; 3 cycles each; instrCount+2.
- Opcode 0x3F at DECODE → state 12, error=1, all strobes 0, held for 10 cycles; pulsing resetN low returns state=0, error=0, instrCount=0.
- MEM_TIMEOUT=16, memReady=0 in FETCH → state 0 for 16 cycles, ERROR on the 16th edge; with MEM_TIMEOUT=0 it stalls 100 cycles without error.
- resetN low asynchronously (mid-cycle) while in MEMWR → state=0 immediately, no memWrite afterward, instrCount unchanged from its pre-instruction value.
